bias_accum_relu: RTL

- Downstream consumer of the per-layer BIAS_layerXX constant banks.
- Accumulates N_CHUNKS beats of signed partial sums from the adder tree for N_adder_tree output lanes.
- On the final beat, adds the per-lane 18-bit bias, applies ReLU and saturates to 18 bits.
- Holds the result under a valid/ready handshake for the next layer's buffer.

---
 rtl/bias_accum_relu.sv | 116 +++++++++++
 1 files changed

// File: rtl/bias_accum_relu.sv
// ============================================================================
// Module      : bias_accum_relu
// Description : Per-lane partial-sum accumulator with bias add, ReLU and
//               18-bit saturation, presented under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bias_accum_relu #(
  parameter int N_adder_tree = 16,
  parameter int DW           = 18,
  parameter int ACC_W        = 24,
  parameter int N_CHUNKS     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       layer_start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_adder_tree*DW-1:0] psum,
  input  logic [N_adder_tree*DW-1:0] bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_adder_tree*DW-1:0] out_data,
  output logic [5:0]                 beat_cnt
);

  localparam int         c_vec_w     = N_adder_tree * DW;
  localparam logic [5:0] c_last_beat = 6'(N_CHUNKS - 1);

  logic               r_out_valid;
  logic [c_vec_w-1:0] r_out_data;
  logic [5:0]         r_beat_cnt;

  logic               w_accept;
  logic               w_first;
  logic               w_final;
  logic [c_vec_w-1:0] w_lane_result;

  // A stalled result blocks every beat, so accumulators freeze with it.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready && !layer_start;
  assign w_first  = (r_beat_cnt == 6'd0);
  assign w_final  = (r_beat_cnt == c_last_beat);

  generate
    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
      logic [ACC_W-1:0] r_acc;
      logic [ACC_W-1:0] w_acc_base;
      logic [ACC_W-1:0] w_psum_ext;
      logic [ACC_W-1:0] w_acc_next;
      logic [ACC_W:0]   w_bias_ext;
      logic [ACC_W:0]   w_sum;
      logic [DW-1:0]    w_relu;

      // Beat 0 ignores the accumulator, so stale contents never need clearing.
      assign w_acc_base = w_first ? '0 : r_acc;
      assign w_psum_ext = {{(ACC_W-DW){psum[DW*i+DW-1]}}, psum[DW*i +: DW]};
      assign w_bias_ext = {{(ACC_W+1-DW){bias[DW*i+DW-1]}}, bias[DW*i +: DW]};
      assign w_acc_next = w_acc_base + w_psum_ext;

      assign w_sum = {w_acc_base[ACC_W-1], w_acc_base}
                   + {w_psum_ext[ACC_W-1], w_psum_ext}
                   + w_bias_ext;

      always_comb begin
        w_relu = w_sum[DW-1:0];
        if (w_sum[ACC_W]) begin
          w_relu = '0;
        end else if (|w_sum[ACC_W-1:DW-1]) begin
          w_relu = {1'b0, {(DW-1){1'b1}}};
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_acc <= '0;
        end else if (w_accept && !w_final) begin
          r_acc <= w_acc_next;
        end
      end

      assign w_lane_result[DW*i +: DW] = w_relu;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (layer_start) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= w_final ? 6'd0 : r_beat_cnt + 6'd1;
    end
  end

  // A final beat landing while the old result drains keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept && w_final) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_lane_result;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign beat_cnt  = r_beat_cnt;

endmodule

`default_nettype wire
